// File: rtl/seven_seg_display_fsm_pkg.sv
// seven_seg_pkg: shared format codes, converter states and segment decoding for the display driver
package seven_seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [1:0] FMT_DEC = 2'd0;
  localparam logic [1:0] FMT_HEX = 2'd1;
  localparam logic [1:0] FMT_BCD = 2'd2;
  localparam logic [1:0] FMT_OFF = 2'd3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [31:0] BCD_MAX = 32'd99_999_999;
  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_LOAD} cv_state_t;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'h40;
      4'h1: seg_of = 7'h79;
      4'h2: seg_of = 7'h24;
      4'h3: seg_of = 7'h30;
      4'h4: seg_of = 7'h19;
      4'h5: seg_of = 7'h12;
      4'h6: seg_of = 7'h02;
      4'h7: seg_of = 7'h78;
      4'h8: seg_of = 7'h00;
      4'h9: seg_of = 7'h10;
      4'hA: seg_of = 7'h08;
      4'hB: seg_of = 7'h03;
      4'hC: seg_of = 7'h46;
      4'hD: seg_of = 7'h21;
      4'hE: seg_of = 7'h06;
      default: seg_of = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_display_fsm_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, 32-bit binary to 8 saturated BCD digits, result valid with o_done
module bin2bcd_seq
  import seven_seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_bin,
  output logic [31:0] o_bcd,
  output logic        o_busy,
  output logic        o_done
);
  cv_state_t r_state, w_next;
  logic [31:0] r_bin, r_work;
  logic [27:0] w_adj;
  logic [4:0]  r_cnt;
  // the top digit stays below 5 because the operand is saturated to 8 digits
  for (genvar d = 0; d < NUM_DIGITS - 1; d++) begin : g_adj
    assign w_adj[4*d +: 4] = r_work[4*d +: 4] >= 4'd5 ? r_work[4*d +: 4] + 4'd3 : r_work[4*d +: 4];
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == CV_IDLE  ? (i_start ? CV_SHIFT : CV_IDLE) :
             r_state == CV_SHIFT ? (&r_cnt ? CV_LOAD : CV_SHIFT) : CV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= CV_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (r_state == CV_IDLE && i_start) begin
      r_bin  <= i_bin > BCD_MAX ? BCD_MAX : i_bin;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (r_state == CV_SHIFT) begin
      r_work <= {r_work[30:28], w_adj, r_bin[31]};
      r_bin  <= {r_bin[30:0], 1'b0};
      r_cnt  <= r_cnt + 5'd1;
    end
  end
  assign o_bcd  = r_work;
  assign o_busy = r_state != CV_IDLE;
  assign o_done = r_state == CV_LOAD;
endmodule

// File: rtl/seven_seg_display_fsm.sv
// seven_seg_display_fsm: scans 8 common-anode digits, showing a value as decimal, hex, packed BCD or blank
module seven_seg_display_fsm
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [1:0]  display_number_format,
  input  logic [31:0] number_to_display,
  input  logic [7:0]  decimal_points,
  output logic [7:0]  cathode,
  output logic [7:0]  anode
);
  localparam int CW = $clog2(DIGIT_PERIOD);
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_bcd, w_bcd;
  logic [7:0]    r_anode, r_cathode;
  logic [3:0]    w_dnib, w_hnib;
  logic [6:0]    w_seg;
  logic          w_last, w_lz, w_busy, w_done;
  bin2bcd_seq u_bcd (
    .clk    (clock),
    .rst    (rst),
    .i_start(~w_busy),
    .i_bin  (number_to_display),
    .o_bcd  (w_bcd),
    .o_busy (w_busy),
    .o_done (w_done)
  );
  assign w_last = r_cnt == CW'(DIGIT_PERIOD - 1);
  assign w_dnib = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_hnib = number_to_display[{r_idx, 2'b00} +: 4];
  // a digit is a leading zero when it and everything above it is zero; digit 0 always shows
  assign w_lz   = r_idx != 3'd0 && (r_bcd >> {r_idx, 2'b00}) == 32'd0;
  assign w_seg  = display_number_format == FMT_DEC ? (w_lz ? SEG_BLANK : seg_of(w_dnib)) :
                  display_number_format == FMT_HEX ? seg_of(w_hnib) :
                  display_number_format == FMT_BCD && w_hnib <= 4'd9 ? seg_of(w_hnib) : SEG_BLANK;
  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_bcd     <= '0;
      r_anode   <= 8'hFF;
      r_cathode <= 8'hFF;
    end else begin
      r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
      r_idx     <= r_idx + {2'b00, w_last};
      r_bcd     <= w_done ? w_bcd : r_bcd;
      r_anode   <= ~(8'd1 << r_idx);
      r_cathode <= display_number_format == FMT_OFF ? 8'hFF : {~decimal_points[r_idx], w_seg};
    end
  end
  assign anode   = r_anode;
  assign cathode = r_cathode;
endmodule

// File: tb/tb_seven_seg_display_fsm.sv
// tb_seven_seg_display_fsm: directed checks of scan order, all four formats and reset mid-conversion
module tb_seven_seg_display_fsm;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  fmt = 2'd3;
  logic [31:0] num = '0;
  logic [7:0]  dp = 8'hFF;
  logic [7:0]  cathode, anode;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  seven_seg_display_fsm #(.DIGIT_PERIOD(4)) dut (
    .clock                (clock),
    .rst                  (rst),
    .display_number_format(fmt),
    .number_to_display    (num),
    .decimal_points       (dp),
    .cathode              (cathode),
    .anode                (anode)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic digit(input int i, input logic [7:0] exp, input string tag);
    logic [7:0] a;
    a = ~(8'd1 << i);
    for (int n = 0; n < 64 && anode !== a; n++) @(negedge clock);
    chk({tag, "_an"}, {24'd0, anode}, {24'd0, a});
    chk(tag, {24'd0, cathode}, {24'd0, exp});
  endtask
  task automatic show(input logic [1:0] f, input logic [31:0] v, input logic [7:0] d,
                      input int settle, input logic [63:0] exp, input string tag);
    fmt = f;
    num = v;
    dp  = d;
    repeat (settle) @(negedge clock);
    for (int i = 0; i < 8; i++) digit(i, exp[8*i +: 8], $sformatf("%s%0d", tag, i));
  endtask
  initial begin
    logic [7:0] e;
    repeat (3) begin
      @(negedge clock);
      chk("rst_an", {24'd0, anode}, 32'hFF);
      chk("rst_cat", {24'd0, cathode}, 32'hFF);
    end
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clock);
      e = ~(8'd1 << ((i / 4) % 8));
      chk($sformatf("scan%0d", i), {24'd0, anode}, {24'd0, e});
      chk($sformatf("off%0d", i), {24'd0, cathode}, 32'hFF);
    end
    show(2'd1, 32'h12AB_CDEF, 8'h00, 2, 64'hF9A4_8883_C6A1_868E, "hex");
    show(2'd0, 32'd1234, 8'h00, 70, 64'hFFFF_FFFF_F9A4_B099, "d1234_");
    show(2'd0, 32'd0, 8'h00, 70, 64'hFFFF_FFFF_FFFF_FFC0, "dzero");
    show(2'd0, 32'hFFFF_FFFF, 8'h00, 70, 64'h9090_9090_9090_9090, "dsat");
    show(2'd2, 32'h0000_59A3, 8'h04, 2, 64'hC0C0_C0C0_9210_FFB0, "bcd");
    show(2'd3, 32'h1234_5678, 8'hFF, 2, 64'hFFFF_FFFF_FFFF_FFFF, "blank");
    show(2'd0, 32'd1234, 8'h00, 70, 64'hFFFF_FFFF_F9A4_B099, "pre");
    num = 32'd5678;
    repeat (10) @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_bcd", dut.r_bcd, 32'd0);
    chk("rst2_an", {24'd0, anode}, 32'hFF);
    chk("rst2_cat", {24'd0, cathode}, 32'hFF);
    rst = 1'b0;
    show(2'd0, 32'd5678, 8'h00, 70, 64'hFFFF_FFFF_9282_F880, "d5678_");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_display_fsm.md
Name: seven_seg_display_fsm

Overview:
- Time-multiplexed driver for the 8-digit, common-anode seven-segment display.
- Takes a 32-bit value, a 2-bit format code and 8 decimal-point enables, and scans one digit at a time.
- Drives active-low anode and cathode lines.
- Sits at the top level and is fed by the stopwatch/leaderboard datapath, which selects what is shown.

Parameters:
- DIGIT_PERIOD, 100000: clock cycles each digit stays enabled (1 kHz per digit at 100 MHz); must be at least 2.
- NUM_DIGITS, 8: number of digits scanned; fixed at 8, not overridable.

Ports:
- clock  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- display_number_format  input  2  0 = decimal, 1 = hexadecimal, 2 = packed BCD, 3 = blank
- number_to_display  input  32  value to show
- decimal_points  input  8  bit i = 1 lights the DP of digit i (digit 0 = rightmost)
- cathode  output  8  {dp,g,f,e,d,c,b,a}, active low
- anode  output  8  bit i = 0 enables digit i, active low

Behaviour:
- Reset (rst high at a clock edge):
  - anode = 8'hFF, cathode = 8'hFF.
  - Scan counter = 0, digit index = 0, BCD result register = 0, converter idle.
- Scan:
  - Counter counts 0..DIGIT_PERIOD-1, then wraps.
  - On wrap, digit index increments 0→7→0.
  - anode = ~(1 << index); exactly one anode is low at any time after reset.
- Outputs are registered.
  - anode/cathode reflect the index and inputs sampled on the previous edge (1-cycle latency).
  - First edge after reset release: anode = 8'hFE.
- Segment codes, active low, cathode[6:0]:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
  - Blank = 7F.
- cathode[7] = ~decimal_points[index] in every format except 3.
- Format 0 (decimal):
  - number_to_display is converted to 8 BCD digits by a sequential double-dabble converter.
  - Converter snapshots the input when idle, runs 32 shift cycles, then loads the BCD result register atomically on the next cycle.
  - It restarts immediately; no partial result is ever displayed.
  - Input change reaches the BCD register within 68 cycles.
  - Values > 99,999,999 saturate to 99999999.
  - Leading zeros are blanked; digit 0 always shows a numeral (value 0 shows a single "0").
- Format 1 (hex): digit i shows nibble number_to_display[4i+3:4i], no blanking, sampled directly (no converter latency).
- Format 2 (BCD): digit i shows nibble i; nibbles > 9 are shown blank.
- Format 3: cathode = 8'hFF (all segments and DPs off); anode keeps scanning.
- Format and decimal_points changes take effect on the next clock edge; the scan position is not disturbed.
- The converter runs regardless of format, so switching to format 0 shows a result within 68 cycles.
- Reset mid-conversion: conversion is aborted and the BCD register cleared; a fresh conversion starts after release.

Decomposition:
- Shared package seven_seg_pkg holds:
  - format codes FMT_DEC=0, FMT_HEX=1, FMT_BCD=2, FMT_OFF=3;
  - SEG_BLANK = 7'h7F;
  - a function mapping a 4-bit digit to its 7-bit active-low pattern.
- One sub-module, bin2bcd_seq:
  - 32-bit binary in, 8-digit BCD out with saturation;
  - start/busy/done handshake;
  - same clock and rst.

Test Plan:
- Reset held 3 cycles with DIGIT_PERIOD=4 → anode=FF, cathode=FF during reset. After release, anode walks FE,FD,FB,…,7F, changing every 4 cycles, then wraps to FE.
- Format 1, number 32'h12AB_CDEF, decimal_points 0 → digits 0..7 show F,E,D,C,B,A,2,1.
  - Cathodes 8E,86,A1,C6,83,88,A4,F9 (dp bit high).
- Format 0, number 1234 → after ≤68 cycles, digits 0..3 show 4,3,2,1 (99,B0,A4,F9); digits 4..7 cathode = FF.
- Format 0, number 0 → digit 0 = C0, others FF; number 32'hFFFF_FFFF → all digits show 9 (90).
- Format 2, number 32'h0000_59A3 with decimal_points 8'h04:
  - digit 0 = B0, digit 1 = FF (nibble A blank), digit 2 = 10 (DP on), digit 3 = 92.
- Format 3 with decimal_points FF → cathode FF on all digits while anode keeps scanning.
- Assert rst mid-conversion → BCD register 0 and anode FF; after release, the value re-converts correctly.
